// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback slice.
// Provides XLEN, REG_ADDR_W, REG_X0 and the wb_req_t write-request bundle.
package rf_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// In-order FIFO holding long-latency write requests.
// Ports: clk, rst (async high), push/push_data, pop/pop_data,
//        full, empty, count (occupancy, one extra bit beyond the pointers).
module wb_ll_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  wb_req_t                  push_data,
   input  logic                     pop,
   output wb_req_t                  pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   wb_req_t         mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            do_push, do_pop;

   // Full is judged on the registered count only, so a same-cycle
   // pop never opens a slot for a push.
   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

   // Power-of-two depth: pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: pipeline results win, long-latency
// results queue in a FIFO and drain when the pipeline is not writing.
// Ports: wb_* pipeline result, ll_* long-latency result (valid/ready),
//        reg_write/rd_addr/rd_data to the register file, rs*_addr and
//        rf_rs*_data in, bypassed rs*_data out, ll_stall_req, ll_count.
// Macro REGFILE_WB_BYPASS_EN: when defined, read data is bypassed from
// the in-flight write; otherwise read data passes straight through.
module regfile_writeback
   import rf_pkg::*;
#(
   parameter int XLEN     = rf_pkg::XLEN,
   parameter int LL_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wb_valid,
   input  logic                        wb_reg_write,
   input  logic [4:0]                  wb_rd,
   input  logic [XLEN-1:0]             wb_data,
   input  logic                        ll_valid,
   output logic                        ll_ready,
   input  logic [4:0]                  ll_rd,
   input  logic [XLEN-1:0]             ll_data,
   output logic                        reg_write,
   output logic [4:0]                  rd_addr,
   output logic [XLEN-1:0]             rd_data,
   input  logic [4:0]                  rs1_addr,
   input  logic [4:0]                  rs2_addr,
   input  logic [XLEN-1:0]             rf_rs1_data,
   input  logic [XLEN-1:0]             rf_rs2_data,
   output logic [XLEN-1:0]             rs1_data,
   output logic [XLEN-1:0]             rs2_data,
   output logic                        ll_stall_req,
   output logic [$clog2(LL_DEPTH):0]   ll_count
);

   logic    pipe_req;
   logic    ll_pop;
   logic    ll_full, ll_empty;
   wb_req_t ll_in, ll_head;
   wb_req_t out_q, out_d;
   logic    we_q, we_d;

   assign pipe_req = wb_valid & wb_reg_write & (wb_rd != REG_X0);
   assign ll_pop   = ~pipe_req & ~ll_empty;
   assign ll_in    = '{rd: ll_rd, data: ll_data};

   wb_ll_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ll_valid),
      .push_data (ll_in),
      .pop       (ll_pop),
      .pop_data  (ll_head),
      .full      (ll_full),
      .empty     (ll_empty),
      .count     (ll_count)
   );

   assign ll_ready     = ~ll_full & ~rst;
   assign ll_stall_req = ll_full;

   // An x0 LL entry still pops, but produces no write pulse.
   always_comb begin
      out_d = '0;
      we_d  = 1'b0;
      unique case (1'b1)
         pipe_req: begin
            out_d = '{rd: wb_rd, data: wb_data};
            we_d  = 1'b1;
         end
         ll_pop: begin
            out_d = ll_head;
            we_d  = (ll_head.rd != REG_X0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         we_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         we_q  <= we_d;
      end
   end

   assign reg_write = we_q;
   assign rd_addr   = out_q.rd;
   assign rd_data   = out_q.data;

`ifdef REGFILE_WB_BYPASS_EN
   always_comb begin
      rs1_data = rf_rs1_data;
      rs2_data = rf_rs2_data;
      if (we_q && (rd_addr == rs1_addr) && (rs1_addr != REG_X0))
         rs1_data = rd_data;
      if (we_q && (rd_addr == rs2_addr) && (rs2_addr != REG_X0))
         rs2_data = rd_data;
   end
`else
   assign rs1_data = rf_rs1_data;
   assign rs2_data = rf_rs2_data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed steps followed by
// random traffic, compared against a queue-based reference model.
module tb_regfile_writeback;

   localparam int XLEN  = 64;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             wb_valid, wb_reg_write;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             ll_valid, ll_ready;
   logic [4:0]       ll_rd;
   logic [XLEN-1:0]  ll_data;
   logic             reg_write;
   logic [4:0]       rd_addr;
   logic [XLEN-1:0]  rd_data;
   logic [4:0]       rs1_addr, rs2_addr;
   logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data;
   logic [XLEN-1:0]  rs1_data, rs2_data;
   logic             ll_stall_req;
   logic [1:0]       ll_count;

   regfile_writeback #(.XLEN(XLEN), .LL_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_valid     (wb_valid),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .ll_valid     (ll_valid),
      .ll_ready     (ll_ready),
      .ll_rd        (ll_rd),
      .ll_data      (ll_data),
      .reg_write    (reg_write),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rf_rs1_data  (rf_rs1_data),
      .rf_rs2_data  (rf_rs2_data),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .ll_stall_req (ll_stall_req),
      .ll_count     (ll_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } req_t;

   req_t            q[$];
   logic            m_we;
   logic [4:0]      m_rd;
   logic [XLEN-1:0] m_data;
   int              tests = 0;
   int              fails = 0;
   int              writes_seen = 0;

   task automatic chk(input string tag, input logic [XLEN-1:0] got,
                      input logic [XLEN-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] byp(input logic [4:0] a,
                                           input logic [XLEN-1:0] rf);
`ifdef REGFILE_WB_BYPASS_EN
      if (m_we && a == m_rd && a != 5'd0) return m_data;
`endif
      return rf;
   endfunction

   task automatic check_outputs();
      chk("reg_write", XLEN'(reg_write), XLEN'(m_we));
      if (m_we) begin
         chk("rd_addr", XLEN'(rd_addr), XLEN'(m_rd));
         chk("rd_data", rd_data, m_data);
      end
      chk("ll_count", XLEN'(ll_count), XLEN'(q.size()));
      chk("ll_stall_req", XLEN'(ll_stall_req), XLEN'(q.size() == DEPTH));
      chk("ll_ready", XLEN'(ll_ready), XLEN'(q.size() < DEPTH));
      // rs1 always aims at the current write target, rs2 at random
      rs1_addr    = rd_addr;
      rs2_addr    = 5'($urandom_range(0, 31));
      rf_rs1_data = {$urandom, $urandom};
      rf_rs2_data = {$urandom, $urandom};
      #1;
      chk("rs1_data", rs1_data, byp(rs1_addr, rf_rs1_data));
      chk("rs2_data", rs2_data, byp(rs2_addr, rf_rs2_data));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, check.
   task automatic cycle(input logic v, input logic w, input logic [4:0] rd,
                        input logic [XLEN-1:0] d, input logic lv,
                        input logic [4:0] lrd, input logic [XLEN-1:0] ld);
      logic room;
      req_t e;
      wb_valid = v; wb_reg_write = w; wb_rd = rd; wb_data = d;
      ll_valid = lv; ll_rd = lrd; ll_data = ld;
      room = (q.size() < DEPTH);
      if (v && w && rd != 5'd0) begin
         m_we = 1'b1; m_rd = rd; m_data = d;
      end else if (q.size() > 0) begin
         e = q.pop_front();
         m_we = (e.rd != 5'd0); m_rd = e.rd; m_data = e.data;
      end else begin
         m_we = 1'b0; m_rd = 5'd0; m_data = '0;
      end
      if (lv && room) q.push_back('{rd: lrd, data: ld});
      @(posedge clk);
      #1;
      if (reg_write) writes_seen++;
      check_outputs();
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   initial begin
      rst = 1'b1;
      wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
      ll_valid = 0; ll_rd = 0; ll_data = 0;
      rs1_addr = 0; rs2_addr = 0; rf_rs1_data = 0; rf_rs2_data = 0;
      m_we = 0; m_rd = 0; m_data = 0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_reg_write", XLEN'(reg_write), '0);
      chk("rst_rd_addr", XLEN'(rd_addr), '0);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_ll_count", XLEN'(ll_count), '0);
      chk("rst_stall", XLEN'(ll_stall_req), '0);
      chk("rst_ll_ready", XLEN'(ll_ready), '0);
      rst = 1'b0;
      #1;
      chk("rel_ll_ready", XLEN'(ll_ready), XLEN'(1));

      // plain pipeline write, rs1 reads the same register
      cycle(1, 1, 5'd5, 64'h2A, 0, 0, 0);
      // pipeline write to x0 is filtered
      cycle(1, 1, 5'd0, 64'h55, 0, 0, 0);
      // LL entry to x0: counted, popped, no write
      cycle(0, 0, 0, 0, 1, 5'd0, 64'h99);
      idle();
      // contention: LL rd7 waits behind two pipeline writes
      cycle(0, 0, 0, 0, 1, 5'd7, 64'h77);
      cycle(1, 1, 5'd3, 64'h33, 0, 0, 0);
      cycle(1, 1, 5'd4, 64'h44, 0, 0, 0);
      idle();
      // full: pipeline writes continuously, third LL offer refused
      cycle(1, 1, 5'd8, 64'h80, 1, 5'd10, 64'hA0);
      cycle(1, 1, 5'd9, 64'h90, 1, 5'd11, 64'hB0);
      cycle(1, 1, 5'd12, 64'hC0, 1, 5'd13, 64'hD0);
      // drain in consecutive cycles
      idle();
      idle();
      idle();

      // reset mid-drain with two entries queued
      cycle(1, 1, 5'd1, 64'h11, 1, 5'd20, 64'h200);
      cycle(1, 1, 5'd2, 64'h22, 1, 5'd21, 64'h210);
      wb_valid = 0; ll_valid = 0;
      #4;
      rst = 1'b1;
      #1;
      chk("arst_reg_write", XLEN'(reg_write), '0);
      chk("arst_ll_count", XLEN'(ll_count), '0);
      chk("arst_ll_ready", XLEN'(ll_ready), '0);
      q.delete();
      m_we = 0; m_rd = 0; m_data = 0;
      @(posedge clk); #1;
      chk("arst_hold_we", XLEN'(reg_write), '0);
      rst = 1'b0;
      #1;
      chk("arst_rel_ready", XLEN'(ll_ready), XLEN'(1));
      idle();
      idle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 31)), {$urandom, $urandom},
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               {$urandom, $urandom});
      end
      for (int i = 0; i < DEPTH + 1; i++) idle();

      chk("writes_seen", XLEN'(writes_seen > 100), XLEN'(1));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writer side of the integer register-file write port. It merges in-order pipeline results from the MEM/WB stage with out-of-order long-latency results (multiply/divide) onto the single write port. It registers the selected write and drives `rd_addr`/`rd_data`/`reg_write` into the register file. It also bypasses the in-flight write onto the two read ports, so a same-cycle read of the register being written returns the new value.

## Interface
- `XLEN`, default 64: data width.
- `LL_DEPTH`, default 2: long-latency result FIFO depth, power of two, minimum 2.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `wb_valid` in 1: pipeline result valid this cycle; no backpressure.
- `wb_reg_write` in 1: pipeline result writes a register.
- `wb_rd` in 5: pipeline destination.
- `wb_data` in XLEN: pipeline result.
- `ll_valid` in 1: long-latency result offered.
- `ll_ready` out 1: FIFO can accept.
- `ll_rd` in 5: long-latency destination.
- `ll_data` in XLEN: long-latency result.
- `reg_write` out 1: register-file write enable.
- `rd_addr` out 5: register-file write address.
- `rd_data` out XLEN: register-file write data.
- `rs1_addr`, `rs2_addr` in 5 each: read addresses, the same ones fed to the register file.
- `rf_rs1_data`, `rf_rs2_data` in XLEN each: raw register-file read data.
- `rs1_data`, `rs2_data` out XLEN each: bypassed read data.
- `ll_stall_req` out 1: FIFO full; request a pipeline bubble.
- `ll_count` out $clog2(LL_DEPTH)+1: FIFO occupancy.

## Operation
- Pipeline request (`pipe_req`) = `wb_valid & wb_reg_write & (wb_rd != 0)`.
- Per-cycle selection for the write port:
  - If `pipe_req` is high, the pipeline wins.
  - Otherwise, if the FIFO is non-empty, the FIFO head is popped and written.
  - Otherwise the port is idle.
- FIFO push occurs on `ll_valid & ll_ready`. `ll_ready = !full`, derived from the registered count only, never from the same-cycle pop.
  - When the FIFO is full, no push happens even if a pop occurs that cycle.
- An LL entry with `ll_rd == 0` is accepted and popped normally. Its output cycle has `reg_write` = 0.
- The FIFO is strict in-order, with no reordering.
  - The hazard unit guarantees that no pipeline write targets an `rd` with an outstanding LL write; this block performs no check.
- Pipeline writes can starve the FIFO indefinitely. `ll_stall_req` (= full) is the hazard unit's cue to insert a bubble.
- Bypass, combinational: `rs1_data` = `rd_data` if `reg_write & (rd_addr == rs1_addr) & (rs1_addr != 0)`, else `rf_rs1_data`. `rs2_data` follows the same rule with rs2.
- Reset (asynchronous, any time, including mid-drain):
  - `reg_write`=0, `rd_addr`=0, `rd_data`=0, and the FIFO is emptied.
  - `ll_count`=0, `ll_stall_req`=0.
  - `ll_ready`=0 while `rst` is high and 1 from the first cycle after release.
  - Entries queued at reset are lost.

## Timing
- Pipeline: inputs sampled at edge N, outputs valid after N, and the register file commits at edge N+1.
- LL: accepted at edge N and eligible for selection in cycle N+1. If not preempted, outputs are valid after edge N+1 and the register file commits at edge N+2.
- Back-to-back: one write per cycle sustained. With the FIFO full and no pipeline writes, it drains at one entry per cycle and `ll_ready` rises the cycle after the first pop.
- `ll_count` and `ll_stall_req` reflect state after each edge.
- Bypass adds no latency; it is purely combinational on `rd_addr`/`rd_data`/`reg_write`.

## Configuration
- `REGFILE_WB_BYPASS_EN`:
  - Defined: bypass muxes are present as described in Operation.
  - Undefined: `rs1_data` = `rf_rs1_data` and `rs2_data` = `rf_rs2_data`, passed straight through. Consumers must then stall one cycle on a same-register read-after-write.

## Structure
- Shared package `rf_pkg`:
  - `XLEN`, `REG_ADDR_W` (5), `REG_X0` (5'd0).
  - `wb_req_t` struct {`rd`, `data`}, reused by both the FIFO and the output register.
- Sub-module `wb_ll_fifo`: a parameterised synchronous FIFO with count, `full`/`empty`, and push/pop. It uses pointer wrap at `LL_DEPTH` and an extra count bit to distinguish full from empty.

## Test plan
- Pipeline write only: `wb_valid`=1, `wb_reg_write`=1, `wb_rd`=5, `wb_data`=0x2A -> after the next edge `reg_write`=1, `rd_addr`=5, `rd_data`=0x2A; with `rs1_addr`=5 and `rf_rs1_data`=0, `rs1_data`=0x2A.
- x0 filtering: pipeline write to rd=0 -> `reg_write` stays 0. LL push with `ll_rd`=0 -> `ll_count` goes 1 then 0, with no write pulse.
- Contention: push LL (rd=7, 0x77), then pipeline writes rd=3/rd=4 for two cycles -> outputs rd=3, rd=4, then rd=7 with 0x77 in the third output cycle.
- Full/backpressure: with `LL_DEPTH`=2, push two entries while the pipeline writes continuously -> `ll_ready`=0, `ll_stall_req`=1, and a third `ll_valid` is not accepted. Drop `wb_valid` -> the two entries drain in consecutive cycles and `ll_ready` returns to 1 the cycle after the first pop.
- Reset mid-drain: FIFO holding 2 entries, assert `rst` asynchronously between edges -> `reg_write`=0 immediately, `ll_count`=0, `ll_ready`=0. After release: no stale writes and `ll_ready`=1.
- Bypass compiled out (`REGFILE_WB_BYPASS_EN` undefined): the same-register read during a write returns `rf_rs1_data` unchanged.
